// File: rtl/exposure_monitor_pkg.sv
// exposure_monitor_pkg
//   Shared definitions for the exposure-trigger path: default core clock rate,
//   record field widths and the receive-side FSM state encoding. The trigger
//   generator uses the same clock rate and record widths.
package exposure_monitor_pkg;

  // 125 MHz core clock
  localparam int CLK_PER_USEC_DEFAULT = 125;

  // Record field widths
  localparam int WIDTH_W = 16;
  localparam int IMU_W   = 8;
  localparam int SEQ_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH     = 2'd1,
    ST_EMIT     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } mon_state_e;

endpackage

// File: rtl/exposure_monitor_sync.sv
// exposure_monitor_sync
//   Brings the asynchronous sensor exposure strobe into the core clock domain,
//   optionally rejects short glitches, and produces single-cycle edge pulses.
//   Optional feature macro: STROBE_GLITCH_FILTER_EN. When defined, the
//   synchronized strobe must hold a new level for FILTER_LEN consecutive cycles
//   before the edge is accepted. When undefined, the synchronized strobe is used
//   directly.
// Ports
//   c       in   core clock
//   rst_n   in   asynchronous reset, active low
//   strobe  in   raw exposure strobe (asynchronous)
//   lvl     out  accepted strobe level
//   rise    out  one-cycle pulse on accepted rising edge
//   fall    out  one-cycle pulse on accepted falling edge
module exposure_monitor_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic c,
  input  logic rst_n,
  input  logic strobe,
  output logic lvl,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("exposure_monitor_sync: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   strobe_s;

  // Stage p0: metastability synchronizer chain
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], strobe};
    end
  end

  assign strobe_s = sync_p0[SYNC_STAGES-1];

`ifdef STROBE_GLITCH_FILTER_EN
  localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt_p1;
  logic             lvl_p1;
  logic             lvl_p2;

  // Stage p1: stability counter; the level flips only after FILTER_LEN
  // consecutive samples disagree with it
  // Stage p2: previous accepted level for edge detection
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
      lvl_p1 <= 1'b0;
      lvl_p2 <= 1'b0;
    end else begin
      lvl_p2 <= lvl_p1;
      if (strobe_s == lvl_p1) begin
        cnt_p1 <= '0;
      end else if (cnt_p1 == CNT_LAST) begin
        cnt_p1 <= '0;
        lvl_p1 <= strobe_s;
      end else begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
    end
  end

  assign lvl  = lvl_p1;
  assign rise = lvl_p1 & ~lvl_p2;
  assign fall = ~lvl_p1 & lvl_p2;
`else
  logic lvl_p1;

  // Stage p1: previous synchronized level for edge detection
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      lvl_p1 <= 1'b0;
    end else begin
      lvl_p1 <= strobe_s;
    end
  end

  assign lvl  = strobe_s;
  assign rise = strobe_s & ~lvl_p1;
  assign fall = ~strobe_s & lvl_p1;
`endif

endmodule

// File: rtl/exposure_monitor.sv
// exposure_monitor
//   Receive end of the camera exposure-trigger path. Measures the width of each
//   exposure strobe in usec, counts IMU samples between exposure starts and
//   emits one record per exposure over a valid/ready stream.
//   Optional feature macro: STROBE_GLITCH_FILTER_EN (see exposure_monitor_sync).
// Ports
//   c               in   core clock
//   rst_n           in   asynchronous reset, active low
//   strobe          in   sensor exposure strobe, asynchronous, high = exposing
//   imu_sync        in   one-cycle pulse per IMU sample
//   timeout_usec    in   max legal strobe-high time, 0 disables
//   rec_valid       out  record available
//   rec_ready       in   consumer accepts when rec_valid & rec_ready
//   rec_width_usec  out  measured high time (saturating)
//   rec_imu_cnt     out  IMU pulses since previous exposure start (saturating)
//   rec_seq         out  exposure sequence number (wrapping)
//   rec_timeout     out  record closed by timeout rather than strobe fall
//   overrun         out  sticky: a record was dropped
module exposure_monitor
  import exposure_monitor_pkg::*;
#(
  parameter int CLK_PER_USEC = CLK_PER_USEC_DEFAULT,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4
) (
  input  logic               c,
  input  logic               rst_n,
  input  logic               strobe,
  input  logic               imu_sync,
  input  logic [WIDTH_W-1:0] timeout_usec,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [WIDTH_W-1:0] rec_width_usec,
  output logic [IMU_W-1:0]   rec_imu_cnt,
  output logic [SEQ_W-1:0]   rec_seq,
  output logic               rec_timeout,
  output logic               overrun
);

  localparam int               DIV_W    = (CLK_PER_USEC > 1) ? $clog2(CLK_PER_USEC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_USEC - 1);

  function automatic logic [WIDTH_W-1:0] sat_inc_width(input logic [WIDTH_W-1:0] v);
    sat_inc_width = (v == {WIDTH_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [IMU_W-1:0] sat_inc_imu(input logic [IMU_W-1:0] v);
    sat_inc_imu = (v == {IMU_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic str_lvl;
  logic str_rise;
  logic str_fall;

  exposure_monitor_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync (
    .c      (c),
    .rst_n  (rst_n),
    .strobe (strobe),
    .lvl    (str_lvl),
    .rise   (str_rise),
    .fall   (str_fall)
  );

  mon_state_e         state_q;
  mon_state_e         state_nxt;
  logic [DIV_W-1:0]   div_q;
  logic [WIDTH_W-1:0] width_q;
  logic [IMU_W-1:0]   imu_cnt_q;
  logic [IMU_W-1:0]   imu_cap_q;
  logic [SEQ_W-1:0]   seq_q;
  logic               to_q;

  logic usec_tick;
  logic rise_take;
  logic timeout_hit;
  logic rec_load;

  assign usec_tick   = (div_q == DIV_LAST);
  assign rise_take   = (state_q == ST_IDLE) && str_rise;
  assign timeout_hit = (timeout_usec != '0) && (width_q >= timeout_usec);
  // A record is dropped only when an unaccepted one is still on the port
  assign rec_load    = (state_q == ST_EMIT) && (!rec_valid || rec_ready);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:     if (str_rise) state_nxt = ST_HIGH;
      ST_HIGH:     if (str_fall || timeout_hit) state_nxt = ST_EMIT;
      ST_EMIT:     state_nxt = to_q ? ST_WAIT_LOW : ST_IDLE;
      ST_WAIT_LOW: if (!str_lvl) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Measurement stage: usec divider, width, IMU interval and timeout flag
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      width_q   <= '0;
      imu_cnt_q <= '0;
      imu_cap_q <= '0;
      to_q      <= 1'b0;
    end else begin
      // Restarting the divider on the edge gives 1 usec resolution from the rise
      if (rise_take || usec_tick) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + 1'b1;
      end

      if (rise_take) begin
        width_q <= '0;
      end else if ((state_q == ST_HIGH) && usec_tick && !timeout_hit) begin
        width_q <= sat_inc_width(width_q);
      end

      // A pulse coincident with the rise belongs to the interval being closed
      if (rise_take) begin
        imu_cap_q <= imu_sync ? sat_inc_imu(imu_cnt_q) : imu_cnt_q;
        imu_cnt_q <= '0;
      end else if (imu_sync) begin
        imu_cnt_q <= sat_inc_imu(imu_cnt_q);
      end

      if (rise_take) begin
        to_q <= 1'b0;
      end else if ((state_q == ST_HIGH) && !str_fall && timeout_hit) begin
        to_q <= 1'b1;
      end
    end
  end

  // Record stage: output register, sequence number and overrun flag
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      seq_q          <= '0;
      rec_valid      <= 1'b0;
      rec_width_usec <= '0;
      rec_imu_cnt    <= '0;
      rec_seq        <= '0;
      rec_timeout    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (state_q == ST_EMIT) begin
        seq_q <= seq_q + 1'b1;
        if (!rec_load) begin
          overrun <= 1'b1;
        end
      end

      if (rec_load) begin
        rec_valid      <= 1'b1;
        rec_width_usec <= width_q;
        rec_imu_cnt    <= imu_cap_q;
        rec_seq        <= seq_q;
        rec_timeout    <= to_q;
      end else if (rec_ready) begin
        rec_valid <= 1'b0;
      end
    end
  end

endmodule
